// File: rtl/result_drain_pkg.sv
// result_drain_pkg
// Shared definitions for the result drain stream: FSM state encoding,
// default widths, skid buffer depth and FP32 field helpers.
package result_drain_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIM_WIDTH_DEF  = 16;

    // Entries in the output skid buffer; two cover the 1-cycle SRAM latency
    // so the stream keeps one beat per cycle.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FETCH = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam int         FP32_SIGN_BIT = 31;
    localparam logic [7:0] FP32_EXP_ONES = 8'hFF;

    // NaN: exponent all ones with a non-zero mantissa (infinities excluded).
    function automatic logic fp32_is_nan(input logic [31:0] w);
        return (w[30:23] == FP32_EXP_ONES) && (w[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// result_skid_fifo
// Two-entry FIFO holding {data,row,col,last} beats between the SRAM read
// return and the output stream.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, wr_data     write one entry (accepted when not full, or when
//                     full and popping in the same cycle)
//   pop               remove the head entry (ignored when empty)
//   rd_data           head entry, stable until popped
//   count             current occupancy 0..2
//   empty, full       occupancy flags
module result_skid_fifo
    import result_drain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);

endmodule

// File: rtl/result_drain_stream.sv
// result_drain_stream
// Reads result SRAM addresses 0..m*p-1 in order after a start request and
// presents each word on a valid/ready stream with row/column indices and a
// last flag. A 2-entry skid buffer absorbs the 1-cycle SRAM read latency.
// Optional build macro RESULT_DRAIN_RELU_EN: applies FP32 ReLU to out_data
// at the buffer output (negative non-NaN words, including -0, become +0).
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start, num_rows, num_cols  drain request and dimensions (IDLE only)
//   busy, done                 transfer in progress / one-cycle completion
//   sram_result_read_address   registered read address
//   sram_result_read_data      data for the previous cycle's address
//   out_valid, out_ready       stream handshake
//   out_data, out_row, out_col, out_last  beat payload
module result_drain_stream
    import result_drain_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_result_read_address,
    input  logic [DATA_WIDTH-1:0] sram_result_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DIM_WIDTH-1:0]  out_row,
    output logic [DIM_WIDTH-1:0]  out_col,
    output logic                  out_last
);

    localparam int CNT_W   = 2 * DIM_WIDTH;
    localparam int ENTRY_W = DATA_WIDTH + 2 * DIM_WIDTH + 1;

    state_t                state;
    state_t                state_nx;
    logic [DIM_WIDTH-1:0]  rows_q;
    logic [DIM_WIDTH-1:0]  cols_q;
    logic [CNT_W-1:0]      total_q;
    logic [CNT_W-1:0]      issue_cnt;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DIM_WIDTH-1:0]  row_p0;
    logic [DIM_WIDTH-1:0]  col_p0;
    logic                  last_p0;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [DIM_WIDTH-1:0]  row_p1;
    logic [DIM_WIDTH-1:0]  col_p1;
    logic                  last_p1;
    logic                  accept;
    logic                  pop;
    logic                  credit_ok;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic [DATA_WIDTH-1:0] head_data;

`ifdef RESULT_DRAIN_RELU_EN
    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
        if (w[FP32_SIGN_BIT] && !fp32_is_nan(w)) begin
            return '0;
        end
        return w;
    endfunction
`endif

    assign accept    = (state == IDLE) && start;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // A new read may issue only if, after this edge, buffered entries plus
    // the read already in flight leave a free slot. Counting this cycle's pop
    // is what lets the stream sustain one beat per cycle.
    assign credit_ok = vld_p1 ? (fifo_empty || (pop && !fifo_full))
                              : (!fifo_full || pop);
    assign vld_p0    = (state == FETCH) && (issue_cnt != total_q) && credit_ok;
    assign last_p0   = (row_p0 == rows_q - DIM_WIDTH'(1)) &&
                       (col_p0 == cols_q - DIM_WIDTH'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            // Zero-size matrices are detected on the registered total, one
            // cycle after the start is accepted.
            FETCH: begin
                if (total_q == '0) begin
                    state_nx = DONE;
                end else if (vld_p0 && (issue_cnt == total_q - CNT_W'(1))) begin
                    state_nx = DRAIN;
                end
            end
            // Leave once nothing is in flight and the buffer empties at this edge.
            DRAIN: if (!vld_p1 && (fifo_count == {1'b0, pop})) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: issue read address and the indices of the word it returns
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            total_q   <= '0;
            issue_cnt <= '0;
            addr_p0   <= '0;
            row_p0    <= '0;
            col_p0    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rows_q    <= num_rows;
                cols_q    <= num_cols;
                total_q   <= CNT_W'(num_rows) * CNT_W'(num_cols);
                issue_cnt <= '0;
                addr_p0   <= '0;
                row_p0    <= '0;
                col_p0    <= '0;
            end else if (vld_p0) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
                addr_p0   <= addr_p0 + ADDR_WIDTH'(1);
                if (col_p0 == cols_q - DIM_WIDTH'(1)) begin
                    col_p0 <= '0;
                    row_p0 <= row_p0 + DIM_WIDTH'(1);
                end else begin
                    col_p0 <= col_p0 + DIM_WIDTH'(1);
                end
            end
        end
    end

    // Stage p1: SRAM data returns; indices travel alongside into the buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            row_p1  <= '0;
            col_p1  <= '0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                row_p1  <= row_p0;
                col_p1  <= col_p0;
                last_p1 <= last_p0;
            end
        end
    end

    assign push_entry = {sram_result_read_data, row_p1, col_p1, last_p1};

    result_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (vld_p1),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Stage p2: buffer head drives the stream
    assign {head_data, out_row, out_col, out_last} = head_entry;

`ifdef RESULT_DRAIN_RELU_EN
    assign out_data = relu(head_data);
`else
    assign out_data = head_data;
`endif

    assign sram_result_read_address = addr_p0;
    assign busy                     = (state != IDLE);
    assign done                     = (state == DONE);

endmodule
